// File: rtl/divider_seq_nr_pkg.sv
// Shared FSM encoding and constants for the sequential non-restoring divider.
package divider_seq_nr_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PREP = 2'd1,
      S_ITER = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   // Replicated to REG_SIZE to form the divide-by-zero quotient (all ones).
   localparam logic DIV0_QUOTIENT_BIT = 1'b1;

endpackage

// File: rtl/divider_seq_nr_step.sv
// One combinational non-restoring division step: shift {P,Q} left, then add or
// subtract the divisor magnitude depending on the sign of the old partial remainder.
module div_nr_step #(
   parameter int REG_SIZE = 32
) (
   input  logic signed [REG_SIZE:0]   p,
   input  logic        [REG_SIZE-1:0] q,
   input  logic signed [REG_SIZE:0]   dv_mag,
   output logic signed [REG_SIZE:0]   p_next,
   output logic        [REG_SIZE-1:0] q_next
);

   logic signed [REG_SIZE:0] p_sh;

   always_comb begin
      p_sh = {p[REG_SIZE-1:0], q[REG_SIZE-1]};
      if (!p[REG_SIZE]) p_next = p_sh - dv_mag;
      else              p_next = p_sh + dv_mag;
      // Quotient bit equals the restoring trial-subtract outcome, so no final correction is needed.
      q_next = {q[REG_SIZE-2:0], ~p_next[REG_SIZE]};
   end

endmodule

// File: rtl/divider_seq_nr.sv
// Multi-cycle signed/unsigned non-restoring divider, one add/sub per clock,
// with start/busy/done handshake and divide-by-zero flag.
module divider_seq_nr
   import divider_seq_nr_pkg::*;
#(
   parameter int REG_SIZE = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                is_signed,
   input  logic [REG_SIZE-1:0] Dividend,
   input  logic [REG_SIZE-1:0] Divisor,
   output logic [REG_SIZE-1:0] Quotient,
   output logic [REG_SIZE-1:0] Remainder,
   output logic                busy,
   output logic                done,
   output logic                div_by_zero
);

   localparam int CW = $clog2(REG_SIZE);

   state_t                   state, state_nx;
   logic [CW-1:0]            cnt;
   logic [REG_SIZE-1:0]      dd_r, dv_r, q_r;
   logic                     sgn_r, q_neg, r_neg;
   logic signed [REG_SIZE:0] p_r, p_nx, dv_mag;
   logic [REG_SIZE-1:0]      q_nx, dd_abs, dv_abs, rem_mag, quo_nx, rem_nx;
   logic                     dz_c, ovf_c;
   logic                     accept, prep_en, iter_en, fix_en, busy_nx;

   // ---------------- FSM: state register
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // ---------------- FSM: next state
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (start) state_nx = S_PREP;
         S_PREP:  state_nx = dz_c ? S_FIX : S_ITER;
         S_ITER:  if (cnt == '0) state_nx = S_FIX;
         S_FIX:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs / datapath enables
   always_comb begin
      accept  = 1'b0;
      prep_en = 1'b0;
      iter_en = 1'b0;
      fix_en  = 1'b0;
      unique case (state)
         S_IDLE:  accept  = start;
         S_PREP:  prep_en = 1'b1;
         S_ITER:  iter_en = 1'b1;
         S_FIX:   fix_en  = 1'b1;
         default: ;
      endcase
      busy_nx = (state_nx != S_IDLE);
   end

   // ---------------- operand conditioning
   always_comb begin
      dz_c   = (dv_r == '0);
      ovf_c  = sgn_r && (dd_r == {1'b1, {(REG_SIZE-1){1'b0}}}) && (&dv_r);
      // -2^(REG_SIZE-1) negates to itself, which is the correct unsigned magnitude.
      dd_abs = (sgn_r && dd_r[REG_SIZE-1]) ? -dd_r : dd_r;
      dv_abs = (sgn_r && dv_r[REG_SIZE-1]) ? -dv_r : dv_r;
      dv_mag = $signed({1'b0, dv_abs});
   end

   div_nr_step #(.REG_SIZE(REG_SIZE)) u_step (
      .p      (p_r),
      .q      (q_r),
      .dv_mag (dv_mag),
      .p_next (p_nx),
      .q_next (q_nx)
   );

   // ---------------- FIX datapath: restore remainder, apply signs, special cases
   always_comb begin
      // Corrected remainder lies in [0,|Dv|), so the low REG_SIZE bits suffice.
      rem_mag = p_r[REG_SIZE] ? (p_r[REG_SIZE-1:0] + dv_mag[REG_SIZE-1:0])
                              : p_r[REG_SIZE-1:0];
      quo_nx  = q_neg ? -q_r : q_r;
      rem_nx  = r_neg ? -rem_mag : rem_mag;
      if (dz_c) begin
         quo_nx = {REG_SIZE{DIV0_QUOTIENT_BIT}};
         rem_nx = dd_r;
      end else if (ovf_c) begin
         quo_nx = dd_r;
         rem_nx = '0;
      end
   end

   // ---------------- operand, sign and iteration registers
   always_ff @(posedge clock) begin
      if (accept) begin
         dd_r  <= Dividend;
         dv_r  <= Divisor;
         sgn_r <= is_signed;
      end
      if (prep_en) begin
         // Q starts as |Dd|; quotient bits enter at the bottom as dividend bits leave the top.
         p_r   <= '0;
         q_r   <= dd_abs;
         q_neg <= sgn_r & (dd_r[REG_SIZE-1] ^ dv_r[REG_SIZE-1]);
         r_neg <= sgn_r & dd_r[REG_SIZE-1];
         cnt   <= CW'(REG_SIZE-1);
      end else if (iter_en) begin
         p_r   <= p_nx;
         q_r   <= q_nx;
         cnt   <= cnt - 1'b1;
      end
   end

   // ---------------- registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         Quotient    <= '0;
         Remainder   <= '0;
         div_by_zero <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         busy <= busy_nx;
         done <= fix_en;
         if (fix_en) begin
            Quotient    <= quo_nx;
            Remainder   <= rem_nx;
            div_by_zero <= dz_c;
         end
      end
   end

   // done is a single-cycle pulse and never overlaps busy
   a_done_not_busy: assert property (@(posedge clock) disable iff (reset) done |-> !busy);
   a_done_pulse:    assert property (@(posedge clock) disable iff (reset) done |=> !done);

endmodule

// File: tb/tb_divider_seq_nr.sv
// Self-checking bench for divider_seq_nr: directed spec cases plus randomized
// operands at REG_SIZE=32 and REG_SIZE=8 against an integer-arithmetic model.
module tb_divider_seq_nr;

   localparam int W  = 32;
   localparam int W8 = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0, is_signed = 1'b0;
   logic [W-1:0]  dd = '0, dv = '0, quo, rem;
   logic          busy, done, dz;
   logic          start8 = 1'b0, sg8 = 1'b0;
   logic [W8-1:0] dd8 = '0, dv8 = '0, quo8, rem8;
   logic          busy8, done8, dz8;
   int            npass = 0, ntot = 0;

   always #5 clock = ~clock;

   divider_seq_nr #(.REG_SIZE(W)) dut (
      .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
      .Dividend(dd), .Divisor(dv), .Quotient(quo), .Remainder(rem),
      .busy(busy), .done(done), .div_by_zero(dz));

   divider_seq_nr #(.REG_SIZE(W8)) dut8 (
      .clock(clock), .reset(reset), .start(start8), .is_signed(sg8),
      .Dividend(dd8), .Divisor(dv8), .Quotient(quo8), .Remainder(rem8),
      .busy(busy8), .done(done8), .div_by_zero(dz8));

   // Reference: truncating integer division on 64-bit values, w-bit operands.
   function automatic void ref_div(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input bit s, output logic [63:0] q, output logic [63:0] r,
                                   output bit z);
      longint sa, sb;
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      sa = longint'(a & mask);
      sb = longint'(b & mask);
      if (s && a[w-1]) sa = sa - (longint'(1) << w);
      if (s && b[w-1]) sb = sb - (longint'(1) << w);
      if (sb == 0) begin
         q = mask; r = a & mask; z = 1'b1;
      end else begin
         q = 64'(sa / sb) & mask; r = 64'(sa % sb) & mask; z = 1'b0;
      end
   endfunction

   // Launch one op; lat = edges from accept to done (-1 on timeout), bc = busy cycles before done.
   task automatic do32(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                       output int lat, output int bc);
      dd = a; dv = b; is_signed = s; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; dd = $urandom; dv = $urandom; is_signed = 1'($urandom);
      lat = -1; bc = 0;
      for (int k = 0; k <= 100 && lat < 0; k++) begin
         if (k > 0) begin @(posedge clock); #1; end
         if (done) lat = k;
         else if (busy) bc++;
      end
   endtask

   task automatic do8(input logic [W8-1:0] a, input logic [W8-1:0] b, input bit s,
                      output int lat);
      dd8 = a; dv8 = b; sg8 = s; start8 = 1'b1;
      @(posedge clock); #1;
      start8 = 1'b0; dd8 = 8'($urandom); dv8 = 8'($urandom); sg8 = 1'($urandom);
      lat = -1;
      for (int k = 0; k <= 100 && lat < 0; k++) begin
         if (k > 0) begin @(posedge clock); #1; end
         if (done8) lat = k;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      ntot++; if (quo !== '0) $display("FAIL reset_quo got=%h want=0", quo); else npass++;
      ntot++; if (rem !== '0) $display("FAIL reset_rem got=%h want=0", rem); else npass++;
      ntot++; if ({busy, done, dz} !== 3'b000)
         $display("FAIL reset_flags got busy/done/dz=%b want=000", {busy, done, dz}); else npass++;
      ntot++; if ({quo8, rem8, busy8, done8, dz8} !== '0)
         $display("FAIL reset_w8 got=%h want=0", {quo8, rem8, busy8, done8, dz8}); else npass++;
      reset = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_basic;
      logic [W-1:0] ta [5] = '{32'd100, -32'sd100, 32'd100, -32'sd100, 32'hFFFF_FFFF};
      logic [W-1:0] tb [5] = '{32'd7, 32'd7, -32'sd7, -32'sd7, 32'd2};
      bit           ts [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [W-1:0] tq [5] = '{32'd14, -32'sd14, -32'sd14, 32'd14, 32'h7FFF_FFFF};
      logic [W-1:0] tr [5] = '{32'd2, -32'sd2, 32'd2, -32'sd2, 32'd1};
      int lat, bc;
      for (int i = 0; i < 5; i++) begin
         do32(ta[i], tb[i], ts[i], lat, bc);
         ntot++; if (lat !== W + 2) $display("FAIL basic%0d_latency got=%0d want=%0d", i, lat, W + 2); else npass++;
         ntot++; if (bc !== lat || busy !== 1'b0)
            $display("FAIL basic%0d_busy busy_cycles=%0d busy_at_done=%b want=%0d/0", i, bc, busy, lat); else npass++;
         ntot++; if (quo !== tq[i]) $display("FAIL basic%0d_quo got=%h want=%h", i, quo, tq[i]); else npass++;
         ntot++; if (rem !== tr[i]) $display("FAIL basic%0d_rem got=%h want=%h", i, rem, tr[i]); else npass++;
         ntot++; if (dz !== 1'b0) $display("FAIL basic%0d_dz got=%b want=0", i, dz); else npass++;
      end
   endtask

   task automatic test_div0;
      int lat, bc;
      for (int s = 0; s < 2; s++) begin
         do32(32'h1234, 32'h0, 1'(s), lat, bc);
         ntot++; if (lat !== 2) $display("FAIL div0_s%0d_latency got=%0d want=2", s, lat); else npass++;
         ntot++; if (quo !== 32'hFFFF_FFFF) $display("FAIL div0_s%0d_quo got=%h want=ffffffff", s, quo); else npass++;
         ntot++; if (rem !== 32'h1234) $display("FAIL div0_s%0d_rem got=%h want=00001234", s, rem); else npass++;
         ntot++; if (dz !== 1'b1) $display("FAIL div0_s%0d_dz got=%b want=1", s, dz); else npass++;
      end
   endtask

   task automatic test_overflow;
      int lat, bc;
      do32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bc);
      ntot++; if (lat !== W + 2) $display("FAIL ovf_latency got=%0d want=%0d", lat, W + 2); else npass++;
      ntot++; if ({quo, rem, dz} !== {32'h8000_0000, 32'h0, 1'b0})
         $display("FAIL ovf_signed got q=%h r=%h dz=%b want q=80000000 r=0 dz=0", quo, rem, dz); else npass++;
      do32(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bc);
      ntot++; if ({quo, rem, dz} !== {32'h0, 32'h8000_0000, 1'b0})
         $display("FAIL ovf_unsigned got q=%h r=%h dz=%b want q=0 r=80000000 dz=0", quo, rem, dz); else npass++;
   endtask

   task automatic test_ignore_start;
      int lat;
      dd = 32'd1000; dv = 32'd10; is_signed = 1'b0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (5) begin @(posedge clock); #1; end
      dd = 32'd77; dv = 32'd3; is_signed = 1'b1; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      lat = -1;
      for (int k = 6; k <= 100; k++) begin
         if (done) begin lat = k; break; end
         @(posedge clock); #1;
      end
      ntot++; if (lat !== W + 2) $display("FAIL ignore_latency got=%0d want=%0d", lat, W + 2); else npass++;
      ntot++; if ({quo, rem} !== {32'd100, 32'd0})
         $display("FAIL ignore_result got q=%h r=%h want q=00000064 r=0", quo, rem); else npass++;
      repeat (3) begin @(posedge clock); #1; end
      ntot++; if (busy !== 1'b0) $display("FAIL ignore_no_relaunch busy=%b want=0", busy); else npass++;
   endtask

   task automatic test_back_to_back;
      int lat, bc;
      do32(32'd200, 32'd9, 1'b0, lat, bc);
      ntot++; if ({quo, rem} !== {32'd22, 32'd2})
         $display("FAIL b2b_first got q=%h r=%h want q=16 r=2", quo, rem); else npass++;
      // start is raised again in the done cycle itself
      do32(-32'sd50, 32'd6, 1'b1, lat, bc);
      ntot++; if (lat !== W + 2) $display("FAIL b2b_latency got=%0d want=%0d", lat, W + 2); else npass++;
      ntot++; if ({quo, rem} !== {-32'sd8, -32'sd2})
         $display("FAIL b2b_second got q=%h r=%h want q=fffffff8 r=fffffffe", quo, rem); else npass++;
   endtask

   task automatic test_reset_mid;
      int lat, bc, nd;
      dd = 32'd99999; dv = 32'd13; is_signed = 1'b0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (10) begin @(posedge clock); #1; end
      reset = 1'b1;
      @(posedge clock); #1;
      ntot++; if ({quo, rem, busy, done, dz} !== '0)
         $display("FAIL midreset_clear got q=%h r=%h b/d/z=%b want all 0", quo, rem, {busy, done, dz}); else npass++;
      reset = 1'b0;
      nd = 0;
      repeat (40) begin @(posedge clock); #1; if (done) nd++; end
      ntot++; if (nd !== 0) $display("FAIL midreset_no_done got=%0d dones want=0", nd); else npass++;
      do32(32'd12345, 32'd7, 1'b0, lat, bc);
      ntot++; if (lat !== W + 2 || {quo, rem} !== {32'd1763, 32'd4})
         $display("FAIL midreset_recover lat=%0d q=%h r=%h want lat=%0d q=6e3 r=4", lat, quo, rem, W + 2); else npass++;
   endtask

   task automatic test_random32(input int n);
      logic [W-1:0] a, b;
      logic [63:0]  eq, er;
      bit           s, ez;
      int           lat, bc;
      for (int i = 0; i < n; i++) begin
         a = $urandom; s = 1'($urandom);
         case ($urandom_range(0, 9))
            0:       b = '0;
            1:       begin b = '1; if ($urandom_range(0, 1) == 0) a = 32'h8000_0000; end
            2:       b = 32'($urandom_range(1, 15));
            3:       b = -32'($urandom_range(1, 15));
            4:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         ref_div(W, 64'(a), 64'(b), s, eq, er, ez);
         do32(a, b, s, lat, bc);
         ntot++; if (lat !== ((b == '0) ? 2 : W + 2))
            $display("FAIL rand32_%0d_latency a=%h b=%h got=%0d", i, a, b, lat); else npass++;
         ntot++; if (quo !== eq[W-1:0])
            $display("FAIL rand32_%0d_quo a=%h b=%h s=%0d got=%h want=%h", i, a, b, s, quo, eq[W-1:0]); else npass++;
         ntot++; if (rem !== er[W-1:0])
            $display("FAIL rand32_%0d_rem a=%h b=%h s=%0d got=%h want=%h", i, a, b, s, rem, er[W-1:0]); else npass++;
         ntot++; if (dz !== ez)
            $display("FAIL rand32_%0d_dz a=%h b=%h got=%b want=%b", i, a, b, dz, ez); else npass++;
      end
   endtask

   task automatic test_random8(input int n);
      logic [W8-1:0] a, b;
      logic [63:0]   eq, er;
      bit            s, ez;
      int            lat;
      for (int i = 0; i < n; i++) begin
         a = 8'($urandom); s = 1'($urandom);
         case ($urandom_range(0, 7))
            0:       b = '0;
            1:       begin b = '1; if ($urandom_range(0, 1) == 0) a = 8'h80; end
            2:       b = 8'($urandom_range(1, 5));
            default: b = 8'($urandom);
         endcase
         ref_div(W8, 64'(a), 64'(b), s, eq, er, ez);
         do8(a, b, s, lat);
         ntot++; if (lat !== ((b == '0) ? 2 : W8 + 2))
            $display("FAIL rand8_%0d_latency a=%h b=%h got=%0d", i, a, b, lat); else npass++;
         ntot++; if ({quo8, rem8, dz8} !== {eq[W8-1:0], er[W8-1:0], ez})
            $display("FAIL rand8_%0d_result a=%h b=%h s=%0d got q=%h r=%h z=%b want q=%h r=%h z=%b",
                     i, a, b, s, quo8, rem8, dz8, eq[W8-1:0], er[W8-1:0], ez); else npass++;
      end
   endtask

   initial begin
      #(2_000_000);
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_div0();
      test_overflow();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_random32(800);
      test_random8(1500);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
